mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-access controller. Sits between the execute stage and the mem pipeline register.
- Takes the EX-stage memory op, address and store data, checks alignment, and drives a word-addressed data bus with byte enables.
- Sequences wait states on that bus and raises a pipeline stall request until the access completes.
- Load data returns unaligned (full word); alignment and sign extension are done downstream in the mem register.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, bus data width (fixed 4 byte lanes)
- TIMEOUT, 15, max cycles in WAIT before a bus error is flagged

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush
- ex_en  in  1  EX-stage instruction valid
- ex_mem_op  in  4  memory op code (see package)
- ex_addr  in  ADDR_W  effective byte address
- ex_wr_data  in  DATA_W  store data, right-aligned
- bus_rdy  in  1  slave ready / data valid
- bus_as  out  1  address strobe, one-cycle pulse
- bus_rw  out  1  1=write, 0=read
- bus_addr  out  ADDR_W-2  word address
- bus_be  out  4  byte enables
- bus_wr_data  out  DATA_W  lane-replicated store data
- stall_req  out  1  pipeline stall request
- miss_align  out  1  misaligned-access pulse
- bus_err  out  1  timeout pulse
- op_done  out  1  access-complete pulse

Behaviour:
- Reset: all outputs 0; FSM to IDLE; timeout counter 0; cancel flag 0. A reset during ACCESS or WAIT aborts immediately; bus_as is low the next cycle.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE accepts an op when ex_en=1, ex_mem_op!=NOP, flush=0 and the address is aligned.
  - On accept, register bus_addr=ex_addr[ADDR_W-1:2], bus_rw, bus_be, bus_wr_data; go to ACCESS.
  - If flush=1 in IDLE, nothing is accepted.
- Alignment rules:
  - LW/SW need addr[1:0]=00.
  - LH/LHU/SH need addr[0]=0.
  - Byte ops are always aligned.
  - Misaligned valid op: miss_align=1 for one cycle (registered, the cycle after), no bus access, FSM stays IDLE.
- Byte enables and store data:
  - Loads: be=1111.
  - SW: be=1111.
  - SH: be=1100 if addr[1], else 0011; data={2{wr_data[15:0]}}.
  - SB: be=0001<<addr[1:0]; data={4{wr_data[7:0]}}.
- ACCESS: bus_as=1 for exactly this cycle; bus_rdy is sampled.
  - rdy=1: go to IDLE, op_done pulse next cycle.
  - Otherwise go to WAIT.
- WAIT: bus_as=0; bus address, enables and data are held stable; the counter increments each cycle.
  - rdy=1: go to IDLE with op_done.
  - Counter reaches TIMEOUT with no rdy: go to IDLE, bus_err pulse, no op_done.
- stall_req is combinational: 1 when state!=IDLE, or when IDLE is accepting an op this cycle. Latency is 2 cycles minimum (accept, ACCESS); the pipeline resumes the cycle after rdy is seen.
- Flush during ACCESS/WAIT: the bus transaction is not aborted and runs to rdy or timeout. The cancel flag is set and the op_done of that access is suppressed. bus_err is still reported. The flag clears on return to IDLE.
- rdy outside ACCESS/WAIT is ignored.
- Back-to-back ops: a new op can be accepted in the IDLE cycle that follows completion; there is no bubble beyond that.

Decomposition:
- Shared package (bus/signal headers) holds:
  - MEMOP codes: NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
  - FSM state encoding.
  - BE_ALL=4'b1111.
  - Width macros.
- One combinational sub-module, mem_align_chk: op+addr[1:0] -> {misaligned, is_store, be[3:0]}, plus lane replication. It is reused by the mem register for consistency checks.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, rdy held 1 -> next cycle bus_as=1, bus_addr=0x40, be=1111, rw=1; op_done the cycle after; stall_req high for 2 cycles.
- SB addr=0x203, data=0x5A, rdy after 3 wait cycles -> be=1000, wr_data=0x5A5A5A5A held stable through WAIT; op_done once; bus_as pulsed once.
- LH addr=0x101 -> miss_align=1 for one cycle, bus_as never asserted, stall_req stays 0.
- LW with rdy never asserted, TIMEOUT=15 -> bus_err pulse after 15 WAIT cycles, no op_done, FSM back to IDLE.
- LBU issued, flush asserted in WAIT, rdy 2 cycles later -> transaction completes, op_done suppressed, next op accepted normally.
- reset asserted mid-WAIT -> next cycle all outputs 0; a following LW at 0x0 runs normally.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory-access controller: op codes, FSM states,
// byte-enable constants and default widths.
package mem_bus_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int BYTE_LANES  = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [BYTE_LANES-1:0] BE_ALL = 4'b1111;

    typedef enum logic [3:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LW  = 4'd1,
        MEMOP_LH  = 4'd2,
        MEMOP_LHU = 4'd3,
        MEMOP_LB  = 4'd4,
        MEMOP_LBU = 4'd5,
        MEMOP_SW  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SB  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Word-addressed data bus between the memory controller (master) and the
// memory/peripheral slave.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_bus_ctrl_pkg::*;

    logic                    bus_as;
    logic                    bus_rw;
    logic [ADDR_W-3:0]       bus_addr;
    logic [BYTE_LANES-1:0]   bus_be;
    logic [DATA_W-1:0]       bus_wr_data;
    logic                    bus_rdy;

    modport master (
        output bus_as, bus_rw, bus_addr, bus_be, bus_wr_data,
        input  bus_rdy
    );

    modport slave (
        input  bus_as, bus_rw, bus_addr, bus_be, bus_wr_data,
        output bus_rdy
    );

endinterface

// File: rtl/mem_align_chk.sv
// Decodes a memory op against the low address bits: alignment, direction,
// byte enables and lane-replicated store data. Purely combinational.
module mem_align_chk
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]            op,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  is_mem,
    output logic                  misaligned,
    output logic                  is_store,
    output logic [BYTE_LANES-1:0] be,
    output logic [DATA_W-1:0]     lane_data
);

    // Unknown op codes are treated like NOP so they never reach the bus.
    always_comb begin
        is_mem     = 1'b1;
        misaligned = 1'b0;
        is_store   = 1'b0;
        be         = BE_ALL;
        lane_data  = wr_data;
        case (op)
            MEMOP_LW:             misaligned = |addr_lo;
            MEMOP_LH, MEMOP_LHU:  misaligned = addr_lo[0];
            MEMOP_LB, MEMOP_LBU:  misaligned = 1'b0;
            MEMOP_SW: begin
                is_store   = 1'b1;
                misaligned = |addr_lo;
            end
            MEMOP_SH: begin
                is_store   = 1'b1;
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wr_data[DATA_W/2-1:0]}};
            end
            MEMOP_SB: begin
                is_store   = 1'b1;
                be         = 4'b0001 << addr_lo;
                lane_data  = {4{wr_data[DATA_W/4-1:0]}};
            end
            default:              is_mem = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-access controller: accepts EX-stage loads/stores, drives the data
// bus with wait-state and timeout handling, and stalls the pipeline meanwhile.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_en,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wr_data,
    mem_bus_ctrl_if.master    bus,
    output logic              stall_req,
    output logic              miss_align,
    output logic              bus_err,
    output logic              op_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state, state_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  cancel;
    logic                  accept, misalign_hit, done_hit, timeout_hit;

    logic                  chk_is_mem, chk_misaligned, chk_is_store;
    logic [BYTE_LANES-1:0] chk_be;
    logic [DATA_W-1:0]     chk_data;

    mem_align_chk #(.DATA_W(DATA_W)) u_align_chk (
        .op         (ex_mem_op),
        .addr_lo    (ex_addr[1:0]),
        .wr_data    (ex_wr_data),
        .is_mem     (chk_is_mem),
        .misaligned (chk_misaligned),
        .is_store   (chk_is_store),
        .be         (chk_be),
        .lane_data  (chk_data)
    );

    always_comb begin
        accept       = 1'b0;
        misalign_hit = 1'b0;
        done_hit     = 1'b0;
        timeout_hit  = 1'b0;
        state_next   = state;
        case (state)
            ST_IDLE: begin
                if (!reset && ex_en && chk_is_mem && !flush) begin
                    accept       = !chk_misaligned;
                    misalign_hit = chk_misaligned;
                end
                if (accept)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.bus_rdy) begin
                    done_hit   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.bus_rdy) begin
                    done_hit   = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        stall_req = (state != ST_IDLE) || accept;
    end

    assign bus.bus_as = (state == ST_ACCESS);

    // A flush seen at any point of an in-flight access (including the cycle
    // rdy arrives) suppresses its op_done; timeouts are always reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            cancel          <= 1'b0;
            miss_align      <= 1'b0;
            bus_err         <= 1'b0;
            op_done         <= 1'b0;
            bus.bus_rw      <= 1'b0;
            bus.bus_addr    <= '0;
            bus.bus_be      <= '0;
            bus.bus_wr_data <= '0;
        end else begin
            state      <= state_next;
            miss_align <= misalign_hit;
            bus_err    <= timeout_hit;
            op_done    <= done_hit && !(cancel || flush);
            wait_cnt   <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state_next == ST_IDLE)
                cancel <= 1'b0;
            else if (flush && state != ST_IDLE)
                cancel <= 1'b1;
            if (accept) begin
                bus.bus_rw      <= chk_is_store;
                bus.bus_addr    <= ex_addr[ADDR_W-1:2];
                bus.bus_be      <= chk_be;
                bus.bus_wr_data <= chk_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed cases plus randomized ops checked
// against a size/offset reference model of the bus protocol.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int TIMEOUT = 15;

    typedef struct {
        logic [29:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] data;
    } bus_txn_t;

    localparam logic [2:0] EV_DONE = 3'b100;
    localparam logic [2:0] EV_ERR  = 3'b010;
    localparam logic [2:0] EV_MISS = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ex_en = 1'b0;
    logic [3:0]  ex_mem_op = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wr_data = '0;
    logic        stall_req, miss_align, bus_err, op_done;

    int checks = 0;
    int errors = 0;

    bus_txn_t   exp_bus[$];
    logic [2:0] exp_evt[$];

    mem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .ex_en      (ex_en),
        .ex_mem_op  (ex_mem_op),
        .ex_addr    (ex_addr),
        .ex_wr_data (ex_wr_data),
        .bus        (bus.master),
        .stall_req  (stall_req),
        .miss_align (miss_align),
        .bus_err    (bus_err),
        .op_done    (op_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_as"},      bus.bus_as, 0);
        checkOutput({tag, "_rw"},      bus.bus_rw, 0);
        checkOutput({tag, "_addr"},    bus.bus_addr, 0);
        checkOutput({tag, "_be"},      bus.bus_be, 0);
        checkOutput({tag, "_wdata"},   bus.bus_wr_data, 0);
        checkOutput({tag, "_stall"},   stall_req, 0);
        checkOutput({tag, "_miss"},    miss_align, 0);
        checkOutput({tag, "_err"},     bus_err, 0);
        checkOutput({tag, "_done"},    op_done, 0);
    endtask

    // Monitor: every bus strobe and every completion pulse consumes one entry.
    always @(negedge clk) begin
        bus_txn_t   t;
        logic [2:0] ev;
        if (bus.bus_as) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bus_as: got 1, expected 0 at %0t", $time);
            end else begin
                t = exp_bus.pop_front();
                checkOutput("as_addr", bus.bus_addr, t.addr);
                checkOutput("as_rw",   bus.bus_rw, t.rw);
                checkOutput("as_be",   bus.bus_be, t.be);
                if (t.rw)
                    checkOutput("as_wdata", bus.bus_wr_data, t.data);
            end
        end
        ev = {op_done, bus_err, miss_align};
        if (ev != 3'b000) begin
            if (exp_evt.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got %b, expected none at %0t", ev, $time);
            end else begin
                checkOutput("event", ev, exp_evt.pop_front());
            end
        end
    end

    // Issue one op with the DUT idle. rdy_delay counts cycles after ACCESS
    // (0 = rdy in ACCESS, k = k-th WAIT cycle); flush_at uses the same index.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input int rdy_delay,
                                 input int flush_at);
        int       size, c_end;
        bit       store, done;
        bus_txn_t t;
        size  = (op == MEMOP_LW || op == MEMOP_SW) ? 4 :
                (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) ? 2 : 1;
        store = (op == MEMOP_SW || op == MEMOP_SH || op == MEMOP_SB);
        ex_en       = 1'b1;
        ex_mem_op   = op;
        ex_addr     = addr;
        ex_wr_data  = wd;
        flush       = 1'b0;
        bus.bus_rdy = 1'($urandom % 2);
        if ((addr % size) != 0) begin
            exp_evt.push_back(EV_MISS);
            @(negedge clk);
            checkOutput("stall_misaligned", stall_req, 0);
            nextCycle();
            ex_en       = 1'b0;
            bus.bus_rdy = 1'b0;
            return;
        end
        t.addr = addr[31:2];
        t.rw   = store;
        t.be   = store ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
        for (int i = 0; i < 4; i++)
            t.data[8*i +: 8] = wd[8*(i % size) +: 8];
        exp_bus.push_back(t);
        done  = (rdy_delay <= TIMEOUT);
        c_end = done ? rdy_delay : TIMEOUT;
        if (!done)
            exp_evt.push_back(EV_ERR);
        else if (flush_at > c_end)
            exp_evt.push_back(EV_DONE);
        @(negedge clk);
        checkOutput("stall_accept", stall_req, 1);
        for (int c = 0; c <= c_end; c++) begin
            nextCycle();
            bus.bus_rdy = (c == rdy_delay);
            flush       = (c == flush_at);
            @(negedge clk);
            checkOutput("stall_busy", stall_req, 1);
            checkOutput("hold_addr", bus.bus_addr, t.addr);
            checkOutput("hold_be",   bus.bus_be, t.be);
            if (store)
                checkOutput("hold_wdata", bus.bus_wr_data, t.data);
        end
        nextCycle();
        ex_en       = 1'b0;
        bus.bus_rdy = 1'b0;
        flush       = 1'b0;
    endtask

    // Idle cycles with noise: flushed ops and stray rdy must all be ignored.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_en       = 1'($urandom % 2);
            ex_mem_op   = 4'($urandom_range(1, 8));
            ex_addr     = $urandom;
            flush       = ex_en;
            bus.bus_rdy = 1'($urandom % 2);
            @(negedge clk);
            checkOutput("stall_idle", stall_req, 0);
            nextCycle();
        end
        ex_en       = 1'b0;
        flush       = 1'b0;
        bus.bus_rdy = 1'b0;
    endtask

    task automatic resetMidWait();
        bus_txn_t t;
        ex_en      = 1'b1;
        ex_mem_op  = MEMOP_LW;
        ex_addr    = 32'h40;
        ex_wr_data = 32'h0;
        t.addr = 30'h10;
        t.rw   = 1'b0;
        t.be   = 4'hF;
        t.data = '0;
        exp_bus.push_back(t);
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            bus.bus_rdy = 1'b0;
        end
        reset = 1'b1;
        ex_en = 1'b0;
        nextCycle();
        @(negedge clk);
        checkAllZero("reset_mid_wait");
        nextCycle();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       r, delay, fat;
        logic [3:0]  op;
        logic [31:0] addr;
        bus.bus_rdy = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkAllZero("reset");
        nextCycle();
        reset = 1'b0;

        applyStimulus(MEMOP_SW,  32'h100, 32'hDEADBEEF, 0, 99);
        idleCycles(1);
        applyStimulus(MEMOP_SB,  32'h203, 32'h0000005A, 4, 99);
        idleCycles(1);
        applyStimulus(MEMOP_LH,  32'h101, 32'h0, 0, 99);
        idleCycles(2);
        applyStimulus(MEMOP_LW,  32'h200, 32'h0, 99, 99);
        idleCycles(1);
        applyStimulus(MEMOP_LBU, 32'h305, 32'h0, 3, 1);
        applyStimulus(MEMOP_LW,  32'h8,   32'h0, 1, 99);
        applyStimulus(MEMOP_SH,  32'h42,  32'h1234ABCD, TIMEOUT, 99);
        applyStimulus(MEMOP_SW,  32'h44,  32'h0, 99, 5);
        idleCycles(1);
        resetMidWait();
        applyStimulus(MEMOP_LW,  32'h0,   32'h0, 0, 99);

        for (int n = 0; n < 150; n++) begin
            op   = 4'($urandom_range(1, 8));
            addr = $urandom;
            if ($urandom % 2 == 1)
                addr = addr & 32'hFFFF_FFFC;
            r     = $urandom % 8;
            delay = (r < 6) ? r : (r == 6) ? TIMEOUT : 20;
            fat   = ($urandom % 4 == 0) ? $urandom_range(0, 16) : 99;
            applyStimulus(op, addr, $urandom, delay, fat);
            idleCycles($urandom_range(0, 2));
        end

        idleCycles(3);
        checkOutput("bus_queue_empty",   exp_bus.size(), 0);
        checkOutput("event_queue_empty", exp_evt.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
